imm_enc: RTL and testbench
==========================

Name: imm_enc

Overview:
- Encoder counterpart of the immediate generator: inserts a 32-bit immediate into the immediate fields of a base instruction word.
- Supports the I/S/B/U/J formats selected by Imm_sel, using the same 3-bit selector encoding the decoder uses.
- Two-stage valid/ready pipeline between an instruction source (assembler/test-stream unit) and instruction memory or fetch-side consumers.
- Required property: when no range error is flagged, decoding the output with the same Imm_sel returns the input Imm exactly.

Parameters:
- WIDTH, 32, instruction and immediate width (only 32 supported)
- IMM_WIDTH, 3, width of Imm_sel

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous reset, active-high
- In_valid  input  1  input beat valid
- In_ready  output  1  encoder can accept a beat
- Base_instr  input  WIDTH  instruction with opcode/rd/rs1/rs2/funct fields; its immediate bit positions are ignored
- Imm_sel  input  IMM_WIDTH  000 I, 001 S, 010 B, 011 U, 100 J (JAL if Base_instr[6:2]==5'b11011, else JALR/I layout)
- Imm  input  WIDTH  immediate value to encode
- Out_valid  output  1  output beat valid
- Out_ready  input  1  consumer accepts the beat
- Out_instr  output  WIDTH  encoded instruction
- Imm_err  output  1  Imm not representable in the selected format (IMM_CHECK_EN only; otherwise tied 0)
- Err_count  output  16  saturating count of errored beats accepted (IMM_CHECK_EN only)

Behaviour:
- Reset (synchronous, active-high): both stage valid bits 0; Out_valid=0; Out_instr=0; Imm_err=0; Err_count=0. In_ready=1 on the first cycle after reset deassertion. Reset asserted mid-stream discards all in-flight beats; no partial beat is emitted.
- Handshake: a beat transfers on In_valid&&In_ready, or on Out_valid&&Out_ready. Out_instr and Imm_err stay stable while Out_valid&&!Out_ready.
- Stage 1: registers Base_instr/Imm_sel/Imm.
- Stage 2: registers the encoded word. Latency is 2 cycles, accept to Out_valid.
- Throughput: 1 beat/cycle. Each stage advances when it is empty or the stage after it advances. In_ready = !s1_valid || s2_advance (combinational from Out_ready; no combinational path from In_valid to Out_valid).
- Encoding: start from Base_instr, then overwrite only the immediate bits for the selected format:
  - I / JALR: Instr[31:20]=Imm[11:0]
  - S: Instr[31:25]=Imm[11:5]; Instr[11:7]=Imm[4:0]
  - B: Instr[31]=Imm[12]; Instr[30:25]=Imm[10:5]; Instr[11:8]=Imm[4:1]; Instr[7]=Imm[11]
  - U: Instr[31:12]=Imm[31:12]
  - JAL: Instr[31]=Imm[20]; Instr[30:21]=Imm[10:1]; Instr[20]=Imm[11]; Instr[19:12]=Imm[19:12]
  - Selector 101–111: Out_instr=Base_instr unchanged, Imm_err=0
- Range rules (IMM_CHECK_EN):
  - I / S / JALR: error unless Imm[31:11] all equal
  - B: error unless Imm[31:12] all equal and Imm[0]==0
  - U: error unless Imm[11:0]==0
  - JAL: error unless Imm[31:20] all equal and Imm[0]==0
  - An errored beat is still encoded (truncated bits) and emitted with Imm_err=1.
- Err_count increments when an errored beat is accepted into stage 1. It saturates at 16'hFFFF and does not wrap.

Optional Feature:
- Macro: IMM_CHECK_EN
- Defined: range checker present; Imm_err travels in the pipeline alongside Out_instr; Err_count is active.
- Undefined: no checker logic; Imm_err=0 and Err_count=0 constantly. Port list is unchanged, so encoding and timing are identical in both builds.

Decomposition:
- Shared package imm_pkg:
  - enum imm_sel_t (IMM_I=3'b000, IMM_S, IMM_B, IMM_U, IMM_J)
  - localparam OPC_JAL_HI=5'b11011
  - Reused by the decoder and this block.
- Sub-module imm_enc_core: combinational format packer plus range check. The top level holds the two pipeline registers and handshake.

Test Plan:
- I-type: Base_instr=32'h00000013, sel=000, Imm=32'hFFFFF800 -> Out_instr=32'h80000013 two cycles after accept, Imm_err=0.
- B-type: Base_instr=32'h00000063, sel=010, Imm=32'h00000FFE -> Out_instr=32'h7E000FE3. Repeat with Imm=32'h00000801 -> Imm_err=1, Err_count=1.
- JAL vs JALR: sel=100, Imm=32'h000FFFFE, Base_instr=32'h0000006F -> 32'h7FFFF06F. Base_instr=32'h00000067 with Imm=32'h000007FF -> 32'h7FF00067.
- Backpressure: stream 4 beats with Out_ready low for cycles 3–6 -> In_ready drops once both stages are full, Out_instr is held stable, all 4 beats are emitted in order with none lost or duplicated.
- Reset mid-stream: assert rst with 2 beats in flight -> next cycle Out_valid=0, Err_count=0, no stale beat emitted afterwards.
- Round trip: 10k random (Base_instr, sel 000–100, Imm) beats through the decoder -> decoded Imm equals input Imm whenever Imm_err=0.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared immediate-format definitions for the immediate encoder and decoder.
// The range-check helper is only referenced when IMM_CHECK_EN is defined.
package imm_pkg;

    localparam int WIDTH     = 32;
    localparam int IMM_WIDTH = 3;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_U = 3'b011,
        IMM_J = 3'b100
    } imm_sel_t;

    // Opcode bits [6:2] that distinguish JAL from JALR under the J selector
    localparam logic [4:0] OPC_JAL_HI = 5'b11011;

    // High when imm cannot be represented exactly in the selected format
    function automatic logic imm_range_err(
        input logic [2:0]  sel,
        input logic        is_jal,
        input logic [31:0] imm
    );
        logic err;
        err = 1'b0;
        case (sel)
            IMM_I, IMM_S: err = !(&imm[31:11] || ~|imm[31:11]);
            IMM_B:        err = !(&imm[31:12] || ~|imm[31:12]) || imm[0];
            IMM_U:        err = |imm[11:0];
            IMM_J: begin
                if (is_jal) err = !(&imm[31:20] || ~|imm[31:20]) || imm[0];
                else        err = !(&imm[31:11] || ~|imm[31:11]);
            end
            default:      err = 1'b0;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/imm_enc_if.sv
// Beat-level interface of the immediate encoder: instruction source in, encoded word out.
interface imm_enc_if #(
    parameter int WIDTH     = 32,
    parameter int IMM_WIDTH = 3
);
    logic                 In_valid;
    logic                 In_ready;
    logic [WIDTH-1:0]     Base_instr;
    logic [IMM_WIDTH-1:0] Imm_sel;
    logic [WIDTH-1:0]     Imm;
    logic                 Out_valid;
    logic                 Out_ready;
    logic [WIDTH-1:0]     Out_instr;
    logic                 Imm_err;
    logic [15:0]          Err_count;

    modport master (
        output In_valid, Base_instr, Imm_sel, Imm, Out_ready,
        input  In_ready, Out_valid, Out_instr, Imm_err, Err_count
    );

    modport slave (
        input  In_valid, Base_instr, Imm_sel, Imm, Out_ready,
        output In_ready, Out_valid, Out_instr, Imm_err, Err_count
    );
endinterface

// File: rtl/imm_enc_core.sv
// Combinational packer: writes an immediate into the I/S/B/U/J fields of a base word.
// Range checking is built only when IMM_CHECK_EN is defined; otherwise err is tied low.
module imm_enc_core
    import imm_pkg::*;
(
    input  logic [31:0] base_instr,
    input  logic [2:0]  imm_sel,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output logic        err
);

    logic is_jal;

    assign is_jal = (base_instr[6:2] == OPC_JAL_HI);

    always_comb begin
        instr = base_instr;
        case (imm_sel)
            IMM_I: instr[31:20] = imm[11:0];
            IMM_S: begin
                instr[31:25] = imm[11:5];
                instr[11:7]  = imm[4:0];
            end
            IMM_B: begin
                instr[31]    = imm[12];
                instr[30:25] = imm[10:5];
                instr[11:8]  = imm[4:1];
                instr[7]     = imm[11];
            end
            IMM_U: instr[31:12] = imm[31:12];
            IMM_J: begin
                // JALR shares the I layout; only a JAL opcode selects the J scramble
                if (is_jal) begin
                    instr[31]    = imm[20];
                    instr[30:21] = imm[10:1];
                    instr[20]    = imm[11];
                    instr[19:12] = imm[19:12];
                end else begin
                    instr[31:20] = imm[11:0];
                end
            end
            default: instr = base_instr;
        endcase
    end

`ifdef IMM_CHECK_EN
    assign err = imm_range_err(imm_sel, is_jal, imm);
`else
    assign err = 1'b0;
`endif

endmodule

// File: rtl/imm_enc.sv
// Two-stage valid/ready immediate encoder: stage 1 holds the request, stage 2 the encoded word.
// Define IMM_CHECK_EN to build the range checker, Imm_err pipeline bit and Err_count.
module imm_enc
    import imm_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int IMM_WIDTH = 3
) (
    input  logic       clk,
    input  logic       rst,
    imm_enc_if.slave   bus
);

    logic                 s1_valid;
    logic [WIDTH-1:0]     s1_base;
    logic [IMM_WIDTH-1:0] s1_sel;
    logic [WIDTH-1:0]     s1_imm;

    logic                 s2_valid;
    logic [WIDTH-1:0]     s2_instr;
    logic                 s2_err;

    logic                 s1_load;
    logic                 s2_load;
    logic [WIDTH-1:0]     enc_instr;
    logic                 enc_err;

    assign s2_load     = !s2_valid || bus.Out_ready;
    assign s1_load     = !s1_valid || s2_load;
    assign bus.In_ready = s1_load;

    imm_enc_core u_core (
        .base_instr (s1_base),
        .imm_sel    (s1_sel),
        .imm        (s1_imm),
        .instr      (enc_instr),
        .err        (enc_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_base  <= '0;
            s1_sel   <= '0;
            s1_imm   <= '0;
            s2_valid <= 1'b0;
            s2_instr <= '0;
            s2_err   <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid <= bus.In_valid;
                if (bus.In_valid) begin
                    s1_base <= bus.Base_instr;
                    s1_sel  <= bus.Imm_sel;
                    s1_imm  <= bus.Imm;
                end
            end
            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_instr <= enc_instr;
                    s2_err   <= enc_err;
                end
            end
        end
    end

    assign bus.Out_valid = s2_valid;
    assign bus.Out_instr = s2_instr;
    assign bus.Imm_err   = s2_err;

`ifdef IMM_CHECK_EN
    logic        in_err;
    logic [15:0] err_count;

    // Counted at stage-1 acceptance, so the checker also looks at the raw input beat
    assign in_err = imm_range_err(bus.Imm_sel, bus.Base_instr[6:2] == OPC_JAL_HI, bus.Imm);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
        end else if (bus.In_valid && s1_load && in_err && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'd1;
        end
    end

    assign bus.Err_count = err_count;
`else
    assign bus.Err_count = 16'd0;
`endif

endmodule

// File: tb/tb_imm_enc.sv
// Scoreboard bench for imm_enc: bit-placement reference model plus decoder round trip.
// Honours IMM_CHECK_EN so the same bench covers both builds.
module tb_imm_enc;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imm_enc_if bus ();

    imm_enc dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef IMM_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        logic [31:0] base;
        logic [2:0]  sel;
        logic [31:0] imm;
        int          fmt;
        logic [31:0] instr;
        logic        err;
    } beat_t;

    beat_t       sb[$];
    int          checks = 0;
    int          errors = 0;
    int          model_errcnt = 0;
    int          out_ready_mode = 1;
    int          emitted = 0;
    logic        held_valid = 1'b0;
    logic [31:0] held_instr = '0;
    logic        held_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Format: 0 I/JALR, 1 S, 2 B, 3 U, 4 JAL, 5 passthrough
    function automatic int fmt_of(input logic [2:0] sel, input logic [31:0] base);
        if (sel == 3'd4) return (base[6:2] == 5'b11011) ? 4 : 0;
        if (sel <= 3'd3) return int'(sel);
        return 5;
    endfunction

    // Instruction bit receiving immediate bit k, or -1 if the format drops it
    function automatic int place(input int f, input int k);
        case (f)
            0: return (k <= 11) ? 20 + k : -1;
            1: return (k <= 4) ? 7 + k : ((k <= 11) ? 20 + k : -1);
            2: begin
                if (k == 11) return 7;
                if (k >= 1 && k <= 4) return 7 + k;
                if (k >= 5 && k <= 10) return 20 + k;
                if (k == 12) return 31;
                return -1;
            end
            3: return (k >= 12) ? k : -1;
            4: begin
                if (k >= 1 && k <= 10) return 20 + k;
                if (k == 11) return 20;
                if (k >= 12 && k <= 19) return k;
                if (k == 20) return 31;
                return -1;
            end
            default: return -1;
        endcase
    endfunction

    function automatic logic [31:0] model_enc(input int f, input logic [31:0] base, input logic [31:0] imm);
        logic [31:0] w;
        int p;
        w = base;
        for (int k = 0; k < 32; k++) begin
            p = place(f, k);
            if (p >= 0) w[p] = imm[k];
        end
        return w;
    endfunction

    function automatic bit model_ok(input int f, input logic [31:0] imm);
        longint v;
        v = longint'($signed(imm));
        case (f)
            0, 1: return (v >= -2048) && (v <= 2047);
            2:    return (v >= -4096) && (v <= 4095) && (imm[0] == 1'b0);
            3:    return (imm % 32'd4096) == 32'd0;
            4:    return (v >= -(64'sd1 <<< 20)) && (v < (64'sd1 <<< 20)) && (imm[0] == 1'b0);
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] model_dec(input int f, input logic [31:0] w);
        case (f)
            0: return {{20{w[31]}}, w[31:20]};
            1: return {{20{w[31]}}, w[31:25], w[11:7]};
            2: return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            3: return {w[31:12], 12'b0};
            4: return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default: return 32'd0;
        endcase
    endfunction

    always @(negedge clk) begin
        case (out_ready_mode)
            0:       bus.Out_ready = 1'b0;
            1:       bus.Out_ready = 1'b1;
            default: bus.Out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Stimulus side of the scoreboard: record every accepted beat
    always @(negedge clk) begin : push_proc
        beat_t b;
        #1;
        if (rst) begin
            sb.delete();
            model_errcnt = 0;
        end else begin
            check("err_count", 32'(bus.Err_count), 32'(model_errcnt));
            if (bus.In_valid && bus.In_ready) begin
                b.base  = bus.Base_instr;
                b.sel   = bus.Imm_sel;
                b.imm   = bus.Imm;
                b.fmt   = fmt_of(b.sel, b.base);
                b.instr = model_enc(b.fmt, b.base, b.imm);
                b.err   = !model_ok(b.fmt, b.imm);
                sb.push_back(b);
                if (CHK && b.err && model_errcnt < 65535) model_errcnt++;
            end
        end
    end

    // Output side: pop and compare on every transferred beat, and check hold stability
    always @(negedge clk) begin : mon_proc
        beat_t b;
        #1;
        if (rst) begin
            held_valid = 1'b0;
        end else begin
            if (held_valid) begin
                check("hold_valid", 32'(bus.Out_valid), 32'd1);
                check("hold_instr", bus.Out_instr, held_instr);
                check("hold_err", 32'(bus.Imm_err), 32'(held_err));
            end
            if (bus.Out_valid && bus.Out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=%h required=none t=%0t", bus.Out_instr, $time);
                end else begin
                    b = sb.pop_front();
                    check("out_instr", bus.Out_instr, b.instr);
                    check("imm_err", 32'(bus.Imm_err), 32'(CHK & b.err));
                    if (!b.err && b.fmt != 5)
                        check("round_trip", model_dec(b.fmt, bus.Out_instr), b.imm);
                    emitted++;
                end
            end
            held_valid = bus.Out_valid && !bus.Out_ready;
            held_instr = bus.Out_instr;
            held_err   = bus.Imm_err;
        end
    end

    task automatic send(input logic [31:0] base, input logic [2:0] sel, input logic [31:0] imm);
        int n;
        n = 0;
        bus.In_valid   = 1'b1;
        bus.Base_instr = base;
        bus.Imm_sel    = sel;
        bus.Imm        = imm;
        #1;
        while (!bus.In_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=stalled required=accept t=%0t", $time);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.In_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.In_valid = 1'b0;
        while ((sb.size() != 0 || bus.Out_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 500) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0 t=%0t", sb.size(), $time);
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_imm();
        logic [31:0] x;
        x = $urandom;
        case ($urandom_range(0, 3))
            0:       return x;
            1:       return {{20{x[11]}}, x[11:0]};
            2:       return {{11{x[20]}}, x[20:1], 1'b0};
            default: return {x[31:12], 12'b0};
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] base;
        logic [2:0]  sel;
        int          e0;
        bit          saw_stall;

        bus.In_valid   = 1'b0;
        bus.Base_instr = '0;
        bus.Imm_sel    = '0;
        bus.Imm        = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", 32'(bus.Out_valid), 32'd0);
        check("rst_out_instr", bus.Out_instr, 32'd0);
        check("rst_imm_err", 32'(bus.Imm_err), 32'd0);
        check("rst_err_count", 32'(bus.Err_count), 32'd0);
        check("rst_in_ready", 32'(bus.In_ready), 32'd1);
        @(negedge clk);

        // I-type with explicit two-cycle latency
        send(32'h00000013, 3'b000, 32'hFFFFF800);
        bus.In_valid = 1'b0;
        #1;
        check("lat_not_yet", 32'(bus.Out_valid), 32'd0);
        @(negedge clk);
        #1;
        check("lat_valid", 32'(bus.Out_valid), 32'd1);
        check("lat_i_instr", bus.Out_instr, 32'h80000013);
        drain();

        send(32'h00000063, 3'b010, 32'h00000FFE);
        send(32'h00000063, 3'b010, 32'h00000801);
        drain();
        check("b_err_count", 32'(bus.Err_count), CHK ? 32'd1 : 32'd0);

        send(32'h0000006F, 3'b100, 32'h000FFFFE);
        send(32'h00000067, 3'b100, 32'h000007FF);
        send(32'h00000037, 3'b011, 32'hABCDE000);
        send(32'h00000023, 3'b001, 32'hFFFFF801);
        send(32'h12345678, 3'b110, 32'hFFFFFFFF);
        drain();

        // Backpressure: four beats while the consumer stalls for four cycles
        e0 = emitted;
        saw_stall = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) send($urandom, 3'($urandom_range(0, 4)), rand_imm());
                bus.In_valid = 1'b0;
            end
            begin
                repeat (2) @(negedge clk);
                out_ready_mode = 0;
                for (int i = 0; i < 4; i++) begin
                    #1;
                    if (bus.In_valid && !bus.In_ready) saw_stall = 1'b1;
                    @(negedge clk);
                end
                out_ready_mode = 1;
            end
        join
        drain();
        check("bp_in_ready_drop", 32'(saw_stall), 32'd1);
        check("bp_beat_count", 32'(emitted - e0), 32'd4);

        // Reset with two beats in flight
        out_ready_mode = 0;
        send(32'h00000063, 3'b010, 32'h00000801);
        send(32'h00000063, 3'b010, 32'h00000803);
        bus.In_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(bus.Out_valid), 32'd0);
        check("mid_rst_err_count", 32'(bus.Err_count), 32'd0);
        check("mid_rst_in_ready", 32'(bus.In_ready), 32'd1);
        out_ready_mode = 1;
        @(negedge clk);
        e0 = emitted;
        idle(8);
        check("mid_rst_no_stale", 32'(emitted - e0), 32'd0);

        // Random round trip under random consumer backpressure
        out_ready_mode = 2;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            base = $urandom;
            if ($urandom_range(0, 9) == 0) begin
                sel = 3'($urandom_range(5, 7));
            end else begin
                sel = 3'($urandom_range(0, 4));
                if (sel == 3'd4) base[6:0] = ($urandom_range(0, 1) != 0) ? 7'h6F : 7'h67;
            end
            send(base, sel, rand_imm());
        end
        out_ready_mode = 1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
